mips_load_store_unit: RTL and testbench



---
 rtl/mips_load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// Load/store unit between the single-cycle datapath and a word-wide
// Harvard data-memory port. It turns a CPU byte/half/word request into a
// word-aligned memory transaction, stalls the CPU until memory completes,
// extends load data, and flags misaligned accesses and memory timeouts.
module mips_load_store_unit #(
  parameter int TIMEOUT   = 200,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2, FAULT = 2'd3} state_t;

  // Counter value seen on the last waiting edge before the abort.
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? {TIMEOUT_W{1'b0}} : TIMEOUT_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [1:0]           size_q, size_d;
  logic                 signed_q, signed_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 misaligned_s;

  // Lane enables for the access; size 11 behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [1:0] size);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] a,
                                               input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {a, 3'b000};
    case (size)
      2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign misaligned_s = (req_size[1] & (req_addr[1:0] != 2'b00)) |
                        ((req_size == 2'b01) & req_addr[0]);

  // State and latched request fields; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {TIMEOUT_W{1'b0}};
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state: accept requests in IDLE, wait out memory in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = {TIMEOUT_W{1'b0}};
          state_d  = misaligned_s ? FAULT : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!mem_waitrequest) begin
          if (!write_q) begin
            rdata_d = load_extract(mem_readdata, addr_q[1:0], size_q, signed_q);
          end else begin
            rdata_d = rdata_q;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
          if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            state_d = FAULT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops them immediately.
  always_comb begin
    stall          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'h0000_0000;
    mem_byteenable = 4'b0000;
    mem_writedata  = 32'h0000_0000;
    case (state_q)
      IDLE: stall = req_valid;
      ACCESS: begin
        stall          = 1'b1;
        mem_read       = !write_q;
        mem_write      = write_q;
        mem_address    = {addr_q[31:2], 2'b00};
        mem_byteenable = byte_en(addr_q[1:0], size_q);
        mem_writedata  = lane_wdata(wdata_q, size_q);
      end
      default: stall = 1'b0;
    endcase
  end

  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == DONE);
  assign err         = (state_q == FAULT);

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit: a vector table of zero-wait
// accesses plus hand sequences for waits, misalignment, timeout and reset.
module tb_mips_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, err, mem_read, mem_write, mem_waitrequest;
  logic [31:0] rdata, mem_address, mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;

  int total = 0;
  int bad   = 0;

  mips_load_store_unit #(.TIMEOUT(5), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic drop_req();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_waitrequest = 1'b0; mem_readdata = 32'h0;

    //        wr    size   sgn   addr          wdata         readdata      be       wdata_out     rdata
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h80FF_7F01, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h80FF_7F01, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0,        32'h80FF_7F01, 4'b0010, 32'h0,        32'h0000_007F};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0,        32'h80FF_7F01, 4'b1100, 32'h0,        32'hFFFF_80FF};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0,        32'h80FF_7F01, 4'b0011, 32'h0,        32'h0000_7F01};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 32'h0000_7F01};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 4'b1111, 32'h1234_5678, 32'h0000_7F01};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        32'h0000_8001, 4'b0011, 32'h0,        32'hFFFF_8001};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,        32'h1234_5681, 4'b0001, 32'h0,        32'h0000_0081};
    vecs[10] = '{1'b0, 2'b11, 1'b1, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D};

    // Reset state (asynchronous, before any clock edge matters).
    #12;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'h0, rdata_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_be", {28'h0, mem_byteenable}, 32'h0);
    chk("rst_wd", mem_writedata, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Zero-wait accesses from the table.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_idle_stall", i), {31'h0, stall}, 32'h1);
      step();
      drop_req();
      mem_readdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_acc_stall", i), {31'h0, stall}, 32'h1);
      chk($sformatf("v%0d_strobes", i), {30'h0, mem_read, mem_write},
          vecs[i].wr ? 32'h1 : 32'h2);
      chk($sformatf("v%0d_addr", i), mem_address, {vecs[i].addr[31:2], 2'b00});
      chk($sformatf("v%0d_be", i), {28'h0, mem_byteenable}, {28'h0, vecs[i].exp_be});
      if (vecs[i].wr) chk($sformatf("v%0d_wd", i), mem_writedata, vecs[i].exp_wd);
      step();
      mem_readdata = 32'h0BAD_0BAD;
      chk($sformatf("v%0d_rvalid", i), {31'h0, rdata_valid}, 32'h1);
      chk($sformatf("v%0d_done_stall", i), {31'h0, stall}, 32'h0);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      step();
      chk($sformatf("v%0d_rvalid_off", i), {31'h0, rdata_valid}, 32'h0);
    end

    // Halfword store with three wait cycles.
    mem_waitrequest = 1'b1;
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1234_ABCD);
    step();
    drop_req();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hs_c%0d_write", i), {30'h0, mem_read, mem_write}, 32'h1);
      chk($sformatf("hs_c%0d_be", i), {28'h0, mem_byteenable}, 32'hC);
      chk($sformatf("hs_c%0d_wd", i), mem_writedata, 32'hABCD_ABCD);
      chk($sformatf("hs_c%0d_addr", i), mem_address, 32'h0000_0300);
      chk($sformatf("hs_c%0d_stall", i), {31'h0, stall}, 32'h1);
      chk($sformatf("hs_c%0d_rvalid", i), {31'h0, rdata_valid}, 32'h0);
      if (i == 3) mem_waitrequest = 1'b0;
      step();
    end
    chk("hs_rvalid", {31'h0, rdata_valid}, 32'h1);
    chk("hs_strobe_off", {30'h0, mem_read, mem_write}, 32'h0);
    chk("hs_rdata_kept", rdata, 32'hCAFE_F00D);
    step();
    chk("hs_rvalid_once", {31'h0, rdata_valid}, 32'h0);

    // Misaligned word load and misaligned half store.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
      else        issue(1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h7777_8888);
      #1;
      chk($sformatf("mis%0d_strobe_idle", k), {30'h0, mem_read, mem_write}, 32'h0);
      step();
      drop_req();
      #1;
      chk($sformatf("mis%0d_err", k), {31'h0, err}, 32'h1);
      chk($sformatf("mis%0d_stall", k), {31'h0, stall}, 32'h0);
      chk($sformatf("mis%0d_strobe", k), {30'h0, mem_read, mem_write}, 32'h0);
      chk($sformatf("mis%0d_rvalid", k), {31'h0, rdata_valid}, 32'h0);
      step();
      chk($sformatf("mis%0d_err_off", k), {31'h0, err}, 32'h0);
      chk($sformatf("mis%0d_strobe_after", k), {30'h0, mem_read, mem_write}, 32'h0);
    end

    // Timeout: waitrequest stuck high with TIMEOUT=5.
    mem_waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    step();
    drop_req();
    n = 0;
    while (mem_read && n < 20) begin
      n++;
      step();
    end
    chk("to_read_cycles", n, 5);
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    chk("to_stall", {31'h0, stall}, 32'h0);
    chk("to_rvalid", {31'h0, rdata_valid}, 32'h0);
    step();
    chk("to_err_off", {31'h0, err}, 32'h0);
    chk("to_idle_strobe", {30'h0, mem_read, mem_write}, 32'h0);

    // Reset in the second wait cycle of a store.
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0050, 32'h9999_0000);
    step();
    drop_req();
    step();
    chk("rm_write_before", {31'h0, mem_write}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rm_write_drop", {31'h0, mem_write}, 32'h0);
    chk("rm_stall_drop", {31'h0, stall}, 32'h0);
    chk("rm_rdata_clr", rdata, 32'h0);
    step();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    step();
    chk("rm_no_retry", {30'h0, mem_read, mem_write}, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    step();
    drop_req();
    mem_readdata = 32'h1122_3344;
    chk("rm_ld_read", {30'h0, mem_read, mem_write}, 32'h2);
    chk("rm_ld_addr", mem_address, 32'h0000_0100);
    step();
    chk("rm_ld_rvalid", {31'h0, rdata_valid}, 32'h1);
    chk("rm_ld_rdata", rdata, 32'h1122_3344);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
